md_unit: RTL

- Multi-cycle multiply/divide unit holding the architectural HI/LO registers for mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Sits beside the ALU in the execute path. It consumes the GRF read operands (rs → srca, rt → srcb) and is driven by a decoded md_op from the control unit.
- busy lets issue logic stall dependent md instructions.
- hi/lo feed the GRF write-back mux for mfhi/mflo.

---
 rtl/md_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit owning architectural HI/LO.
//                Handles mult, multu, div, divu (multi-cycle, busy-stalled)
//                and mthi, mtlo (single cycle). mfhi/mflo read hi/lo directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, dsor_s, dsor_u;
  logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

  // Arithmetic datapath; signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps cleanly and the divisor is never zero.
  always_comb begin
    prod_u = {32'b0, srca} * {32'b0, srcb};
    prod_s = {{32{srca[31]}}, srca} * {{32{srcb[31]}}, srcb};
    a_mag  = srca[31] ? (~srca + 32'd1) : srca;
    b_mag  = srcb[31] ? (~srcb + 32'd1) : srcb;
    dsor_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    dsor_u = (srcb == 32'd0) ? 32'd1 : srcb;
    q_mag  = a_mag / dsor_s;
    r_mag  = a_mag % dsor_s;
    quo_s  = (srca[31] ^ srcb[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = srca[31] ? (~r_mag + 32'd1) : r_mag;
    quo_u  = srca / dsor_u;
    rem_u  = srca % dsor_u;
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Accept requests in IDLE, count down in RUN, commit on counter zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              pend_d    = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_RUN;
            end
            OP_MULTU: begin
              pend_d    = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_RUN;
            end
            OP_DIV: begin
              pend_d    = {rem_s, quo_s};
              pend_wr_d = (srcb != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = S_RUN;
            end
            OP_DIVU: begin
              pend_d    = {rem_u, quo_u};
              pend_wr_d = (srcb != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = srca;
            OP_MTLO: lo_d = srca;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          // Divide by zero leaves pend_wr clear so HI/LO stay untouched.
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire
